// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply / restoring divide on magnitudes, then sign fix-up.
// Latency XLEN+3 cycles from accepted start (2 for divide-by-zero); stalls the pipeline until the done cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic [XLEN-1:0]   a, b, m, hi, lo, res;
  logic              neg, neg_r;

  logic              is_div, signed_a, signed_b, sign_a, sign_b, b_zero;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     msum, rsh, rsub;
  logic              ge;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]   q_f, r_f, fix_val, dz_val;

  // Operand classification and magnitudes, taken from the latched instruction
  assign is_div   = f3[2];
  assign signed_a = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
  assign signed_b = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  assign sign_a   = signed_a & a[XLEN-1];
  assign sign_b   = signed_b & b[XLEN-1];
  assign mag_a    = sign_a ? (~a + 1'b1) : a;
  assign mag_b    = sign_b ? (~b + 1'b1) : b;
  assign b_zero   = is_div && (b == '0);

  // Multiply step: lo holds the remaining multiplier bits, hi the running upper sum
  assign msum = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(XLEN+1){1'b0}});

  // Divide step: hi is the partial remainder, lo shifts dividend bits out and quotient bits in
  assign rsh  = {hi, lo[XLEN-1]};
  assign rsub = rsh - {1'b0, m};
  assign ge   = (rsh >= {1'b0, m});

  assign prod    = {hi, lo};
  assign prod_f  = neg ? (~prod + 1'b1) : prod;
  assign q_f     = neg ? (~lo + 1'b1) : lo;
  assign r_f     = neg_r ? (~hi + 1'b1) : hi;
  assign dz_val  = f3[1] ? a : {XLEN{1'b1}};

  always_comb begin
    fix_val = '0;
    case (f3)
      3'b000:                 fix_val = prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = q_f;
      default:                fix_val = r_f;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (start && !flush) state_nxt = PREP;
    end else if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        PREP:    state_nxt = b_zero ? DONE : CALC;
        CALC:    state_nxt = (cnt == CW'(XLEN-1)) ? FIX : CALC;
        FIX:     state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0; f3 <= '0; a <= '0; b <= '0; m <= '0;
      hi <= '0; lo <= '0; neg <= 1'b0; neg_r <= 1'b0; res <= '0;
    end else begin
      if (state == IDLE && start && !flush) begin
        f3 <= funct3;
        a  <= op_a;
        b  <= op_b;
      end
      if (state == PREP) begin
        neg   <= sign_a ^ sign_b;
        neg_r <= sign_a;
        hi    <= '0;
        lo    <= is_div ? mag_a : mag_b;
        m     <= is_div ? mag_b : mag_a;
        cnt   <= '0;
      end
      if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          hi <= ge ? rsub[XLEN-1:0] : rsh[XLEN-1:0];
          lo <= {lo[XLEN-2:0], ge};
        end else begin
          hi <= msum[XLEN:1];
          lo <= {msum[0], lo[XLEN-1:1]};
        end
      end
      // Result only changes on entry to DONE, so a flushed op leaves it untouched
      if (state_nxt == DONE)
        res <= (state == PREP) ? dz_val : fix_val;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign result    = res;
  assign stall_req = ~reset & ((start & (state == IDLE) & ~flush) |
                     (state == PREP) | (state == CALC) | (state == FIX));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a plain-arithmetic RV32M reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, stall_req, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_res;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .stall_req(stall_req), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, throw random start noise at the busy DUT, and check latency, stall and result
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          lat, exp_lat;
    logic        stall_all;
    logic [31:0] exp_r;
    exp_r   = ref_op(f, a, b);
    exp_lat = (f[2] && b == 0) ? 2 : 35;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    #1 stall_all = stall_req;
    lat = -1;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1)); funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      if (done) begin
        lat = cyc;
        start = 1'b0;
        break;
      end
      stall_all = stall_all & stall_req;
    end
    start = 1'b0;
    chk($sformatf("lat f3=%0d a=%h b=%h", f, a, b), 64'(lat), 64'(exp_lat));
    chk($sformatf("res f3=%0d a=%h b=%h", f, a, b), {32'b0, result}, {32'b0, exp_r});
    chk("stall_busy", {63'b0, stall_all}, 64'd1);
    chk("stall_done", {63'b0, stall_req}, 64'd0);
    last_res = result;
    @(negedge clk);
    chk("busy_after", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    last_res = '0;
    #12;
    chk("rst_busy",   {63'b0, busy}, 64'd0);
    chk("rst_done",   {63'b0, done}, 64'd0);
    chk("rst_stall",  {63'b0, stall_req}, 64'd0);
    chk("rst_result", {32'b0, result}, 64'd0);
    @(negedge clk); reset = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    chk("mul_const", {32'b0, last_res}, 64'hFFFF_FFEB);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    chk("mulh_const", {32'b0, last_res}, 64'h4000_0000);
    do_op(3'd3, 32'h8000_0000, 32'h8000_0000);
    chk("mulhu_const", {32'b0, last_res}, 64'h4000_0000);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulhsu_const", {32'b0, last_res}, 64'hFFFF_FFFF);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    chk("div_const", {32'b0, last_res}, 64'hFFFF_FFFD);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    chk("rem_const", {32'b0, last_res}, 64'hFFFF_FFFF);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", {32'b0, last_res}, 64'h8000_0000);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd5, 32'd5, 32'd0);
    chk("divu_zero", {32'b0, last_res}, 64'hFFFF_FFFF);
    do_op(3'd6, 32'd5, 32'd0);
    chk("rem_zero", {32'b0, last_res}, 64'd5);

    // Flush mid-divide: aborts without a done pulse and keeps the old result
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        saw_done = saw_done | done;
        if (c == 10) flush = 1'b1;
      end
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {63'b0, busy}, 64'd0);
      for (int c = 0; c < 30; c++) begin
        saw_done = saw_done | done;
        @(negedge clk);
      end
      chk("flush_nodone", {63'b0, saw_done}, 64'd0);
      chk("flush_result", {32'b0, result}, {32'b0, last_res});
    end
    do_op(3'd4, 32'd1000, 32'd7);

    // Start together with flush in IDLE is ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    #1 chk("flush_start_stall", {63'b0, stall_req}, 64'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {63'b0, busy}, 64'd0);

    // Asynchronous reset during CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy",   {63'b0, busy}, 64'd0);
    chk("mid_rst_stall",  {63'b0, stall_req}, 64'd0);
    chk("mid_rst_done",   {63'b0, done}, 64'd0);
    chk("mid_rst_result", {32'b0, result}, 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) chk("rst_no_done", 64'd1, 64'd0);
    end

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom), rnd_operand(), rnd_operand());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
